// File: rtl/kong_defs.sv
// Board geometry and Mario state codes, shared by the motion controller and the sprite renderer.
package kong_defs;

    localparam logic [2:0] MARIO_INITIAL  = 3'b000;
    localparam logic [2:0] MARIO_FLYING   = 3'b001;
    localparam logic [2:0] MARIO_JUMPING  = 3'b010;
    localparam logic [2:0] MARIO_WALKING  = 3'b011;
    localparam logic [2:0] MARIO_STANDING = 3'b100;
    localparam logic [2:0] MARIO_DYING    = 3'b101;
    localparam logic [2:0] MARIO_CLAMPING = 3'b110;

    localparam int TOP_BOARD    = 50;
    localparam int BOTTOM_BOARD = 430;
    localparam int LEFT_BOARD   = 50;
    localparam int RIGHT_BOARD  = 590;

    // Sprite is 60x80 and positions refer to its centre.
    localparam int MARIO_HALF_W = 30;
    localparam int MARIO_HALF_H = 40;

endpackage

// File: rtl/sat_add_clamp.sv
// Adds a signed step to an unsigned coordinate in 11-bit signed arithmetic and clamps to [MIN, MAX].
module sat_add_clamp #(
    parameter int W   = 10,
    parameter int MIN = 0,
    parameter int MAX = 1023
) (
    input  logic [W-1:0]       cur_i,
    input  logic signed [10:0] step_i,
    output logic [W-1:0]       res_o
);

    localparam logic signed [10:0] MIN_S = 11'(MIN);
    localparam logic signed [10:0] MAX_S = 11'(MAX);

    logic signed [10:0] sum;

    assign sum = $signed({{(11-W){1'b0}}, cur_i}) + step_i;

    always_comb begin
        if (sum < MIN_S) begin
            res_o = W'(MIN);
        end else if (sum > MAX_S) begin
            res_o = W'(MAX);
        end else begin
            res_o = sum[W-1:0];
        end
    end

endmodule

// File: rtl/mario_motion.sv
// Per-frame Mario movement FSM: turns buttons and collision flags into registered
// position, state and facing for the sprite renderer, updating once per tick.
module mario_motion
    import kong_defs::*;
#(
    parameter logic [9:0] START_X      = 10'd80,
    parameter logic [8:0] START_Y      = 9'd390,
    parameter int         WALK_STEP    = 2,
    parameter int         CLIMB_STEP   = 2,
    parameter int         JUMP_V       = 6,
    parameter int         GRAVITY      = 1,
    parameter int         MAX_FALL     = 8,
    parameter int         INIT_FRAMES  = 30,
    parameter int         DYING_FRAMES = 60
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick,
    input  logic       btn_left,
    input  logic       btn_right,
    input  logic       btn_up,
    input  logic       btn_down,
    input  logic       btn_jump,
    input  logic       on_floor,
    input  logic       on_ladder,
    input  logic       hit,
    output logic [9:0] posX,
    output logic [8:0] posY,
    output logic [2:0] state,
    output logic       facing,
    output logic       died
);

    localparam int X_MIN = LEFT_BOARD + MARIO_HALF_W;
    localparam int X_MAX = RIGHT_BOARD - MARIO_HALF_W;
    localparam int Y_MIN = TOP_BOARD + MARIO_HALF_H;
    localparam int Y_MAX = BOTTOM_BOARD - MARIO_HALF_H;

    logic [9:0] posx_q, posx_d, x_next;
    logic [8:0] posy_q, posy_d, y_next;
    logic [2:0] state_q, state_d;
    logic       facing_q, facing_d;
    logic       died_q, died_d;
    logic [3:0] vy_q, vy_d, vy_fall;
    logic [5:0] cnt_q, cnt_d;

    logic              move_l, move_r, move_h, climb_req;
    logic signed [10:0] dx, dy;

    // Both directions pressed together cancel out.
    assign move_l    = btn_left & ~btn_right;
    assign move_r    = btn_right & ~btn_left;
    assign move_h    = move_l | move_r;
    assign climb_req = on_ladder & (btn_up | btn_down);

    assign vy_fall = (int'(vy_q) + GRAVITY >= MAX_FALL) ? 4'(MAX_FALL)
                                                        : 4'(int'(vy_q) + GRAVITY);

    assign dx = move_r ? 11'(WALK_STEP) : (move_l ? 11'(-WALK_STEP) : 11'sd0);

    always_comb begin
        dy = 11'sd0;
        case (state_q)
            MARIO_JUMPING:  dy = -$signed({7'd0, vy_q});
            MARIO_FLYING:   dy = $signed({7'd0, vy_fall});
            MARIO_CLAMPING: begin
                if (btn_up & ~btn_down)      dy = 11'(-CLIMB_STEP);
                else if (btn_down & ~btn_up) dy = 11'(CLIMB_STEP);
            end
            default:        dy = 11'sd0;
        endcase
    end

    sat_add_clamp #(.W(10), .MIN(X_MIN), .MAX(X_MAX)) u_clamp_x (
        .cur_i  (posx_q),
        .step_i (dx),
        .res_o  (x_next)
    );

    sat_add_clamp #(.W(9), .MIN(Y_MIN), .MAX(Y_MAX)) u_clamp_y (
        .cur_i  (posy_q),
        .step_i (dy),
        .res_o  (y_next)
    );

    always_comb begin
        state_d  = state_q;
        posx_d   = posx_q;
        posy_d   = posy_q;
        facing_d = facing_q;
        vy_d     = vy_q;
        cnt_d    = cnt_q;
        died_d   = 1'b0;

        if (tick) begin
            if (hit && (state_q inside {MARIO_FLYING, MARIO_JUMPING, MARIO_WALKING,
                                        MARIO_STANDING, MARIO_CLAMPING})) begin
                state_d = MARIO_DYING;
                vy_d    = 4'd0;
                cnt_d   = 6'd0;
                died_d  = 1'b1;
            end else begin
                case (state_q)
                    MARIO_INITIAL: begin
                        if (cnt_q == 6'(INIT_FRAMES - 1)) begin
                            state_d = MARIO_STANDING;
                            cnt_d   = 6'd0;
                        end else begin
                            cnt_d = cnt_q + 6'd1;
                        end
                    end
                    MARIO_STANDING, MARIO_WALKING: begin
                        if (!on_floor) begin
                            state_d = MARIO_FLYING;
                            vy_d    = 4'd0;
                        end else if (btn_jump) begin
                            state_d = MARIO_JUMPING;
                            vy_d    = 4'(JUMP_V);
                        end else if (climb_req) begin
                            state_d = MARIO_CLAMPING;
                        end else if (move_h) begin
                            state_d  = MARIO_WALKING;
                            posx_d   = x_next;
                            facing_d = move_l;
                        end else begin
                            state_d = MARIO_STANDING;
                        end
                    end
                    MARIO_JUMPING: begin
                        posx_d = x_next;
                        posy_d = y_next;
                        if (move_h) facing_d = move_l;
                        // Apex or ceiling both hand over to the falling branch at rest.
                        if (vy_q <= 4'd1 || y_next == 9'(Y_MIN)) begin
                            state_d = MARIO_FLYING;
                            vy_d    = 4'd0;
                        end else begin
                            vy_d = vy_q - 4'(GRAVITY);
                        end
                    end
                    MARIO_FLYING: begin
                        if (on_floor) begin
                            state_d = MARIO_STANDING;
                            vy_d    = 4'd0;
                        end else begin
                            vy_d   = vy_fall;
                            posx_d = x_next;
                            posy_d = y_next;
                            if (move_h) facing_d = move_l;
                            if (y_next == 9'(Y_MAX)) begin
                                state_d = MARIO_STANDING;
                                vy_d    = 4'd0;
                            end
                        end
                    end
                    MARIO_CLAMPING: begin
                        if (!on_ladder) begin
                            state_d = on_floor ? MARIO_STANDING : MARIO_FLYING;
                            vy_d    = 4'd0;
                        end else begin
                            posy_d = y_next;
                        end
                    end
                    MARIO_DYING: begin
                        if (cnt_q == 6'(DYING_FRAMES - 1)) begin
                            state_d  = MARIO_INITIAL;
                            cnt_d    = 6'd0;
                            posx_d   = START_X;
                            posy_d   = START_Y;
                            facing_d = 1'b0;
                        end else begin
                            cnt_d = cnt_q + 6'd1;
                        end
                    end
                    default: begin
                        state_d = MARIO_INITIAL;
                        cnt_d   = 6'd0;
                        vy_d    = 4'd0;
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            posx_q   <= START_X;
            posy_q   <= START_Y;
            state_q  <= MARIO_INITIAL;
            facing_q <= 1'b0;
            died_q   <= 1'b0;
            vy_q     <= 4'd0;
            cnt_q    <= 6'd0;
        end else begin
            posx_q   <= posx_d;
            posy_q   <= posy_d;
            state_q  <= state_d;
            facing_q <= facing_d;
            died_q   <= died_d;
            vy_q     <= vy_d;
            cnt_q    <= cnt_d;
        end
    end

    assign posX   = posx_q;
    assign posY   = posy_q;
    assign state  = state_q;
    assign facing = facing_q;
    assign died   = died_q;

endmodule

// File: doc/mario_motion.md
Name: mario_motion

Overview:
- Per-frame Mario movement and state controller.
- Sits directly upstream of the Mario sprite renderer and drives its posX, posY and state inputs.
- Updates once per frame tick from player buttons and from collision flags supplied by the map/collision block.
- All outputs are registered, so the renderer sees stable values for the whole frame.

Parameters:
- START_X, 10'd80: reset/respawn centre x.
- START_Y, 9'd390: reset/respawn centre y.
- WALK_STEP, 2: pixels per tick, horizontal.
- CLIMB_STEP, 2: pixels per tick on a ladder.
- JUMP_V, 6: initial upward speed, pixels/tick.
- GRAVITY, 1: speed change per tick.
- MAX_FALL, 8: fall-speed saturation.
- INIT_FRAMES, 30: ticks spent in INITIAL.
- DYING_FRAMES, 60: ticks spent in DYING.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- tick  in  1  one-cycle pulse per frame (end of active video)
- btn_left  in  1  level, player input
- btn_right  in  1  level, player input
- btn_up  in  1  level, player input
- btn_down  in  1  level, player input
- btn_jump  in  1  level, player input
- on_floor  in  1  feet on a platform at current posX/posY
- on_ladder  in  1  body overlaps a ladder
- hit  in  1  collision with a hazard
- posX  out  10  sprite centre x
- posY  out  9  sprite centre y
- state  out  3  Mario state code
- facing  out  1  0 = right, 1 = left
- died  out  1  one-cycle pulse on entering DYING

Behaviour:
- Reset (rst high at a clk edge, any state): posX=START_X, posY=START_Y, state=INITIAL, facing=0, died=0, vy=0, frame counter=0.
- Reset mid-jump or mid-death aborts immediately.
- State is evaluated only on cycles with tick=1. Registers hold otherwise.
- Latency: new outputs are visible the cycle after the tick.
- died is high only in the cycle after the tick that entered DYING.
- State codes: INITIAL=000, FLYING=001, JUMPING=010, WALKING=011, STANDING=100, DYING=101, CLAMPING=110. Code 111 is illegal and goes to INITIAL.
- Bounds (sprite is 60x80, centre-referenced):
  - posX saturates to [LEFT_BOARD+30, RIGHT_BOARD-30] = [80, 560].
  - posY saturates to [TOP_BOARD+40, BOTTOM_BOARD-40] = [90, 390].
  - Compute next position in 11 bits signed, then clamp. No wrap-around.
- Horizontal input: exactly one of left/right counts as a move. Both pressed counts as no input.
- Priority at each tick:
  1. hit=1 in FLYING, JUMPING, WALKING, STANDING or CLAMPING: go to DYING, vy=0, counter=0, position frozen. hit is ignored in INITIAL and DYING.
  2. Then the per-state rules below.
- INITIAL: count ticks. At INIT_FRAMES go to STANDING. Buttons are ignored.
- STANDING / WALKING, evaluated in this order:
  - !on_floor: FLYING, vy=0.
  - btn_jump: JUMPING, vy=JUMP_V. Jump beats up.
  - btn_up and on_ladder: CLAMPING.
  - btn_down and on_ladder: CLAMPING.
  - Horizontal move: WALKING, posX ± WALK_STEP, facing updated.
  - Otherwise: STANDING.
- JUMPING:
  - posY -= vy, then vy -= GRAVITY.
  - Horizontal move is allowed and updates facing.
  - When vy reaches 0: FLYING. Hitting the top bound also forces FLYING with vy=0.
- FLYING:
  - If on_floor: STANDING, vy=0, no motion this tick.
  - Else: vy = min(vy+GRAVITY, MAX_FALL), posY += vy.
  - Reaching the bottom bound: STANDING.
  - Horizontal move is allowed.
- CLAMPING:
  - !on_ladder: STANDING if on_floor, else FLYING with vy=0.
  - Else: up → posY -= CLIMB_STEP; down → posY += CLIMB_STEP; up and down together → no move.
  - Left/right and jump are ignored.
- DYING: count ticks. At DYING_FRAMES go to INITIAL, posX=START_X, posY=START_Y, facing=0.
- vy is unsigned 4 bits and never exceeds MAX_FALL.

Decomposition:
- Shared package/header (kong_defs): MARIO_* state codes; TOP/BOTTOM/LEFT/RIGHT_BOARD; sprite half-width 30 and half-height 40. Shared with the renderer.
- One sub-module, sat_add_clamp: signed step plus min/max clamp, instantiated once for x and once for y.
- The FSM and counters stay in mario_motion.

Test Plan:
- Reset, then 30 ticks → state 000 for ticks 1-29 and 100 after tick 30; posX=80, posY=390, died=0.
- STANDING with on_floor=1, btn_right held for 3 ticks → state 011, posX 80→82→84→86, facing=0. Then left+right together → state 100, posX=86.
- STANDING with btn_jump for one tick, on_floor=0 afterwards → state 010, posY 390→384→379→375→372→370→369, then state 001. Falling then adds 1, 2, 3…, saturating at 8/tick. Assert on_floor → state 100.
- posX=558 with btn_right held → posX=560 and stays 560. Climbing up at posY=91 → 90 and holds.
- hit during JUMPING → next cycle state 101, died=1 for one cycle, position frozen. After 60 ticks → state 000, posX=80, posY=390. A hit during DYING has no effect.
- on_ladder=1 with btn_up → state 110, posY -= 2 per tick. Drop on_ladder with on_floor=0 → state 001. Assert rst mid-climb → all outputs at reset values on the next cycle.
